// File: rtl/down_ctr_timer.sv
// down_ctr_timer: programmable down-counting timer.
//   Loads load_val on start, decrements once per step while in RUN, and on
//   the terminal step either finishes (DONE) or reloads (auto_reload).
//   abort returns to IDLE from any state and leaves cnt where it is.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   start        one-cycle load/begin request (ignored while in RUN)
//   load_val     start/reload value
//   en           count enable (low pauses)
//   auto_reload  reload at the terminal step instead of finishing
//   abort        return to IDLE
//   cnt          registered current count
//   busy         state == RUN
//   tc           registered one-cycle terminal-count pulse
//   done         state == DONE
//
// Optional build macro PRESCALE_EN: only every PRESCALE-th enabled RUN
// cycle is a step.
module down_ctr_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt_n;
  logic             tc_n;
  logic             tick;
  logic             start_ok;

  if (PRESCALE < 2) begin : g_prescale_chk
    $error("down_ctr_timer: PRESCALE must be >= 2");
  end

  // start is only honoured outside RUN; a running count is never restarted
  assign start_ok = start && (state != RUN);

`ifdef PRESCALE_EN
  localparam int PSW = $clog2(PRESCALE);
  logic [PSW-1:0] psc, psc_n;

  assign tick = (psc == PSW'(PRESCALE - 1));

  // prescaler restarts at every new count or DONE entry so each step takes a
  // full PRESCALE enabled cycles
  always_comb begin
    psc_n = psc;
    if (abort || start_ok || (state_n == DONE && state != DONE))
      psc_n = '0;
    else if (state == RUN && en)
      psc_n = tick ? '0 : psc + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) psc <= '0;
    else     psc <= psc_n;
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tc_n    = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else if (start_ok) begin
      if (load_val == '0) begin
        cnt_n   = '0;
        state_n = DONE;
        tc_n    = 1'b1;
      end else begin
        cnt_n   = load_val;
        state_n = RUN;
      end
    end else if (state == RUN && en && tick) begin
      if (cnt > WIDTH'(1)) begin
        cnt_n = cnt - 1'b1;
      end else begin
        // terminal step; a zero reload value cannot keep running
        tc_n = 1'b1;
        if (auto_reload && load_val != '0) begin
          cnt_n = load_val;
        end else begin
          cnt_n   = '0;
          state_n = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '1;
      tc    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tc    <= tc_n;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/down_ctr_timer.md
Name: down_ctr_timer

Overview:
Programmable down-counting timer. It is the countdown companion to the team's free-running 4-bit up counter: it loads a start value, decrements to zero, then flags completion or reloads for periodic operation. It is used for timeouts, delays and periodic ticks in the design. A small FSM provides start, pause and abort control.

Parameters:
WIDTH, 4, counter width in bits.
PRESCALE, 4, clock-enable divide ratio, must be >= 2. Used only when PRESCALE_EN is defined.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  single-cycle request to load load_val and begin counting.
load_val  input  WIDTH  start and reload value, sampled on accepted start and on reload.
en  input  1  count enable; low pauses counting.
auto_reload  input  1  when high at the terminal step, reload and keep running.
abort  input  1  stop and return to IDLE.
cnt  output  WIDTH  current count (registered).
busy  output  1  high while in RUN.
tc  output  1  one-cycle terminal-count pulse.
done  output  1  high while in DONE.

Behaviour:
- Reset (asserted asynchronously, any time, including mid-count):
  - state=IDLE, cnt={WIDTH{1'b1}}, busy=0, tc=0, done=0.
- States: IDLE, RUN, DONE.
  - busy=(state==RUN), done=(state==DONE). Both are decoded from the state register, so they have no combinational path from inputs.
- Per-edge priority: abort > start > step.
- abort (any state): next state IDLE, cnt holds its current value, tc=0.
- IDLE or DONE with start=1:
  - cnt<=load_val and next state RUN.
  - If load_val==0: cnt<=0, next state DONE, and tc pulses on that edge.
- RUN: start is ignored (no restart).
- A step occurs in RUN when en=1 and the tick is present. The tick is always present unless PRESCALE_EN is defined.
  - cnt>1: cnt<=cnt-1, tc=0.
  - cnt==1 and auto_reload=0: cnt<=0, tc=1 for one cycle, next state DONE.
  - cnt==1 and auto_reload=1: cnt<=load_val, tc=1, stay in RUN. This gives a period of load_val steps.
  - cnt==1, auto_reload=1 and load_val==0: cnt<=0, tc=1, next state DONE.
- RUN with en=0: cnt holds, tc=0.
- DONE: cnt holds 0 until start or abort.
- tc is registered. It is high only in the cycle after a terminal step (or after a start with load_val==0), never for two consecutive cycles unless load_val==1 with auto_reload=1.
- Arithmetic: cnt is unsigned modulo 2^WIDTH. Decrement below 0 is impossible by construction. There is no wrap from 0 to all-ones.
- Latency: with start at edge k, load_val=N>0, en held high and auto_reload=0: cnt=N after edge k, tc and done after edge k+N.

Optional Feature:
PRESCALE_EN
- Defined:
  - A prescaler counter of width $clog2(PRESCALE) advances on each cycle where state==RUN and en=1.
  - A step occurs only when the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler clears on rst, accepted start, abort and entry to DONE, and holds while en=0.
  - Latency from start to done becomes N*PRESCALE cycles.
- Undefined: no prescaler logic, every enabled RUN cycle is a step, and PRESCALE is ignored.

Test Plan:
1. load_val=3, start, en=1, auto_reload=0 -> cnt 3,2,1,0 on successive edges; tc high only in the cycle cnt reads 0; done=1 and busy=0 from then on, cnt stays 0.
2. load_val=2, auto_reload=1, en=1 -> cnt 2,1,2,1,...; tc every 2nd cycle; busy stays 1; done never asserts.
3. load_val=4, en low for 2 cycles after cnt reaches 3 -> cnt holds 3 during the pause; done asserts 6 cycles after start; tc pulses exactly once.
4. In RUN at cnt=5: start alone -> ignored, count continues. Then start and abort together -> IDLE; cnt holds its value; busy=0, done=0, tc=0.
5. load_val=0, start -> next edge cnt=0, state DONE, tc one-cycle pulse. A second start with load_val=2 from DONE -> RUN, cnt=2.
6. load_val=5, start, then assert rst mid-edge-cycle after 2 steps -> immediately (no clock edge) cnt=4'hF, busy=0, done=0, tc=0. With PRESCALE_EN, PRESCALE=4, load_val=2 -> done 8 cycles after start.
